// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned DEF_MIN_WAIT = 1;
  localparam int unsigned DEF_TIMEOUT  = 15;
  localparam int unsigned DEF_CNT_W    = 4;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating wait-cycle counter with clear/enable; flags minimum-wait and timeout.
module mem_wait_counter #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic min_reached,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LP_TO)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign min_reached = (r_cnt >= LP_MIN);
  assign timeout     = (r_cnt == LP_TO);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one access at a time to a variable-latency
// data memory, stalls the pipeline until MemReady, and reports misalignment/timeout.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MIN_WAIT = DEF_MIN_WAIT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              align_err,
  output logic              to_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            r_state;
  state_t            w_next;
  op_t               r_op;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_align_err;
  logic              r_to_err;
  logic              r_mem_we;

  logic w_req;
  logic w_accept;
  logic w_misalign;
  logic w_min_reached;
  logic w_timeout;
  logic w_done;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_rd_done;
  logic w_wr_done;
  logic w_to;

  assign w_req      = req_rd | req_wr;
  assign w_accept   = (r_state == IDLE) & w_req & is_word_aligned(req_addr[1:0]);
  assign w_misalign = (r_state == IDLE) & w_req & ~is_word_aligned(req_addr[1:0]);
  assign w_done     = mem_ready & w_min_reached;

  mem_wait_counter #(
    .CNT_W    (CNT_W),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_wait_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (w_cnt_clr),
    .en          (w_cnt_en),
    .min_reached (w_min_reached),
    .timeout     (w_timeout)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    w_rd_done = 1'b0;
    w_wr_done = 1'b0;
    w_to      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_clr = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        w_cnt_en = 1'b1;
        // A ready that arrives on the timeout cycle still completes the access.
        if (w_done) begin
          w_rd_done = (r_op == OP_RD);
          w_wr_done = (r_op == OP_WR);
          w_next    = DONE;
        end else if (w_timeout) begin
          w_to   = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_RD;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_align_err <= 1'b0;
      r_to_err    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rvalid    <= w_rd_done;
      r_align_err <= w_misalign;
      r_to_err    <= w_to;
      r_mem_we    <= w_wr_done;
      if (w_accept) begin
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_wdata;
        r_op        <= req_wr ? OP_WR : OP_RD;
      end
      if (w_rd_done) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // Reset gating keeps stall low while a request is presented during reset.
  assign stall     = rst_n & ((r_state != IDLE) | w_accept);
  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign align_err = r_align_err;
  assign to_err    = r_to_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed load/store/misalign/timeout/reset cases.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        align_err;
  logic        to_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef enum int {EV_RD, EV_WR, EV_AL, EV_TO} ev_t;
  typedef struct {
    ev_t         kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t evq[$];
  int   latq[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:255];
  int          rc = 0;
  int          delay = 3;
  int          run = 0;

  mem_access_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MIN_WAIT (1),
    .TIMEOUT  (15),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .align_err (align_err),
    .to_err    (to_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: ready asserts once stall has been high for 'delay' edges.
  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = (rc >= delay);

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rc <= 0;
    else if (!stall) rc <= 0;
    else            rc <= rc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon_event(input ev_t k);
    exp_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
      return;
    end
    e = evq.pop_front();
    if (e.kind != k) begin
      errors++;
      $display("FAIL event_kind: got %0d expected %0d at %0t", k, e.kind, $time);
      return;
    end
    case (k)
      EV_RD: if (rdata !== e.data) begin
        errors++; $display("FAIL load_data: got %h expected %h", rdata, e.data);
      end
      EV_WR: if (mem_addr !== e.addr || mem_wdata !== e.data) begin
        errors++; $display("FAIL store_bus: got %h/%h expected %h/%h", mem_addr, mem_wdata, e.addr, e.data);
      end
      EV_AL: if (mem_addr !== e.addr) begin
        errors++; $display("FAIL align_addr: got %h expected %h", mem_addr, e.addr);
      end
      EV_TO: if (rdata !== e.data) begin
        errors++; $display("FAIL timeout_rdata: got %h expected %h", rdata, e.data);
      end
      default: ;
    endcase
  endtask

  // Monitor: pops expected events on output pulses and checks stall run lengths.
  always @(negedge clk) begin
    if (rvalid && to_err) begin
      checks++; errors++;
      $display("FAIL rvalid_to_err_overlap: got both high expected exclusive at %0t", $time);
    end
    if (rvalid)    mon_event(EV_RD);
    if (mem_we)    mon_event(EV_WR);
    if (align_err) mon_event(EV_AL);
    if (to_err)    mon_event(EV_TO);
    if (stall) begin
      run++;
    end else if (run > 0) begin
      checks++;
      if (latq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stall: got %0d cycles expected none", run);
      end else begin
        int exp_run;
        exp_run = latq.pop_front();
        if (run != exp_run) begin
          errors++;
          $display("FAIL stall_cycles: got %0d expected %0d", run, exp_run);
        end
      end
      run = 0;
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    req_rd = ~wr; req_wr = wr; req_addr = addr; req_wdata = data;
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) return;
    end
    checks++; errors++;
    $display("FAIL %s_wait: got stall stuck high expected release within 100 cycles", nm);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"},     {31'd0, stall},     32'd0);
    chk({tag, "_rdata"},     rdata,              32'd0);
    chk({tag, "_rvalid"},    {31'd0, rvalid},    32'd0);
    chk({tag, "_align"},     {31'd0, align_err}, 32'd0);
    chk({tag, "_to"},        {31'd0, to_err},    32'd0);
    chk({tag, "_mem_addr"},  mem_addr,           32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[4]  <= 32'hDEADBEEF;
    mem[12] <= 32'hCAFEF00D;

    // Reset held with an aligned store presented.
    req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'hAAAA5555;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    req_wr = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    // Load 0x10, ready 3 edges after request: req+ISSUE+2 WAIT+DONE.
    delay = 3;
    evq.push_back('{EV_RD, 32'h10, 32'hDEADBEEF});
    latq.push_back(5);
    do_req(1'b0, 32'h10, 32'h0);
    wait_idle("load10");

    // Store 0x20.
    evq.push_back('{EV_WR, 32'h20, 32'h12345678});
    latq.push_back(5);
    do_req(1'b1, 32'h20, 32'h12345678);
    wait_idle("store20");
    chk("store_mem_word", mem[8], 32'h12345678);

    // Load 0x20 with slower memory (6 edges): stall = delay + 2.
    delay = 6;
    evq.push_back('{EV_RD, 32'h20, 32'h12345678});
    latq.push_back(8);
    do_req(1'b0, 32'h20, 32'h0);
    wait_idle("load20");

    // Misaligned load: align_err, no stall, address register untouched.
    evq.push_back('{EV_AL, 32'h20, 32'h0});
    do_req(1'b0, 32'h13, 32'h0);
    wait_idle("misalign");
    repeat (2) @(negedge clk);
    chk("misalign_mem_addr", mem_addr, 32'h20);

    // Ready never rises: req+ISSUE+16 WAIT (cnt 0..15)+DONE = 19 stall cycles.
    delay = 1000;
    evq.push_back('{EV_TO, 32'h30, 32'h12345678});
    latq.push_back(19);
    do_req(1'b0, 32'h30, 32'h0);
    wait_idle("timeout");
    chk("timeout_rdata_kept", rdata, 32'h12345678);
    chk("timeout_mem_word", mem[12], 32'hCAFEF00D);

    // Reset asserted during WAIT of a store: stall seen for 4 negedges.
    latq.push_back(4);
    do_req(1'b1, 32'h30, 32'h55555555);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_stall_after", {31'd0, stall}, 32'd0);
    chk("midreset_mem_word", mem[12], 32'hCAFEF00D);

    // Back-to-back recovery: normal load after the abandoned store.
    delay = 3;
    evq.push_back('{EV_RD, 32'h30, 32'hCAFEF00D});
    latq.push_back(5);
    do_req(1'b0, 32'h30, 32'h0);
    wait_idle("load30");

    repeat (3) @(negedge clk);
    chk("events_left", evq.size(), 32'd0);
    chk("latencies_left", latq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
